// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with lock bursts; ready is combinational, writes land 1 cycle after grant.
// Backpressure: a loser's ready stays low and its inputs are ignored until granted; writes to register 0 are dropped and counted.
module regfile_write_arbiter #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic              read_hazard,
  output logic [7:0]        drop_count
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_t            state;
  logic              last_grant;  // 1 = B was granted last
  logic [3:0]        burst_cnt;
  logic              xfer_a, xfer_b, xfer;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic [3:0]        cnt_inc;
  logic              hz_a, hz_b;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE: begin
          if (a_valid && b_valid) begin
            a_ready = last_grant;
            b_ready = !last_grant;
          end else begin
            a_ready = a_valid;
            b_ready = b_valid;
          end
        end
        OWN_A:   a_ready = a_valid;
        OWN_B:   b_ready = b_valid;
        default: ;
      endcase
    end
  end

  assign xfer_a   = a_valid & a_ready;
  assign xfer_b   = b_valid & b_ready;
  assign xfer     = xfer_a | xfer_b;
  assign sel_lock = xfer_b ? b_lock : a_lock;
  assign sel_reg  = xfer_b ? b_reg  : a_reg;
  assign sel_data = xfer_b ? b_data : a_data;
  assign cnt_inc  = burst_cnt + 4'd1;

  // Only a waiting (not granted) write to a real register can stall a reader.
  assign hz_a = a_valid && !a_ready && (a_reg != '0) && ((a_reg == read_reg_1) || (a_reg == read_reg_2));
  assign hz_b = b_valid && !b_ready && (b_reg != '0) && ((b_reg == read_reg_1) || (b_reg == read_reg_2));
  assign read_hazard = hz_a | hz_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= 4'd0;
    end else begin
      if (xfer) last_grant <= xfer_b;
      case (state)
        IDLE: begin
          if (xfer && sel_lock && (MAX_BURST > 1)) begin
            state     <= xfer_b ? OWN_B : OWN_A;
            burst_cnt <= 4'd1;
          end else begin
            burst_cnt <= 4'd0;
          end
        end
        OWN_A, OWN_B: begin
          if (!xfer || !sel_lock || (cnt_inc == BURST_MAX)) begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
          end else begin
            burst_cnt <= cnt_inc;
          end
        end
        default: begin
          state     <= IDLE;
          burst_cnt <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_reg_write  <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      drop_count    <= 8'd0;
    end else begin
      rf_reg_write <= xfer && (sel_reg != '0);
      if (xfer) begin
        rf_write_reg  <= sel_reg;
        rf_write_data <= sel_data;
        if ((sel_reg == '0) && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule
